// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: one quotient/product bit per cycle (XLEN cycles), or 1 cycle for fast
// multiply and special divides. Busy blocks new starts (never queued); flush aborts without done.
module muldiv_unit #(
   parameter int XLEN     = 32,
   parameter bit FAST_MUL = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_op;
   logic              r_neg_q, r_neg_r;
   logic [XLEN-1:0]   r_a;
   logic [2*XLEN-1:0] r_prod;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_result;

   logic              w_idle, w_is_div, w_s1, w_s2, w_n1, w_n2;
   logic [XLEN-1:0]   w_m1, w_m2;
   logic              w_div0, w_ovf, w_direct, w_accept, w_last;
   logic [2:0]        w_c_op;
   logic              w_c_neg_q, w_c_neg_r;
   logic [XLEN-1:0]   w_c_a;
   logic [2*XLEN-1:0] w_c_prod;
   logic [XLEN:0]     w_sum, w_shift, w_diff;
   logic [2*XLEN-1:0] w_mul_step, w_div_step, w_step, w_full, w_fprod;
   logic [XLEN-1:0]   w_q, w_r, w_final, w_special, w_res_nxt;

   assign w_idle   = (r_state == S_IDLE);
   assign w_is_div = op[2];
   assign w_s1     = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
   assign w_s2     = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
   assign w_n1     = w_s1 & rs1[XLEN-1];
   assign w_n2     = w_s2 & rs2[XLEN-1];
   assign w_m1     = w_n1 ? -rs1 : rs1;
   assign w_m2     = w_n2 ? -rs2 : rs2;
   assign w_div0   = w_is_div & (rs2 == '0);
   assign w_ovf    = w_is_div & ~op[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
   assign w_direct = w_div0 | w_ovf | (~w_is_div & FAST_MUL);
   assign w_accept = w_idle & start & ~flush;
   assign w_last   = (r_state == S_CALC) & (r_cnt == CW'(2));

   // In IDLE the datapath works straight off the ports so the accept edge already retires bit one.
   assign w_c_op    = w_idle ? op : r_op;
   assign w_c_neg_q = w_idle ? (w_n1 ^ w_n2) : r_neg_q;
   assign w_c_neg_r = w_idle ? w_n1 : r_neg_r;
   assign w_c_a     = w_idle ? (w_is_div ? w_m2 : w_m1) : r_a;
   assign w_c_prod  = w_idle ? {{XLEN{1'b0}}, (w_is_div ? w_m1 : w_m2)} : r_prod;

   // Shift-add multiply step and restoring divide step share the {upper, lower} register.
   assign w_sum      = {1'b0, w_c_prod[2*XLEN-1:XLEN]} + (w_c_prod[0] ? {1'b0, w_c_a} : '0);
   assign w_mul_step = {w_sum, w_c_prod[XLEN-1:1]};
   assign w_shift    = {w_c_prod[2*XLEN-1:XLEN], w_c_prod[XLEN-1]};
   assign w_diff     = w_shift - {1'b0, w_c_a};
   assign w_div_step = w_diff[XLEN] ? {w_shift[XLEN-1:0], w_c_prod[XLEN-2:0], 1'b0}
                                    : {w_diff[XLEN-1:0],  w_c_prod[XLEN-2:0], 1'b1};
   assign w_step     = w_c_op[2] ? w_div_step : w_mul_step;

   assign w_full  = w_idle ? (FAST_MUL ? ({{XLEN{1'b0}}, w_m1} * {{XLEN{1'b0}}, w_m2}) : '0) : w_step;
   assign w_fprod = w_c_neg_q ? -w_full : w_full;
   assign w_q     = w_full[XLEN-1:0];
   assign w_r     = w_full[2*XLEN-1:XLEN];

   always_comb begin
      w_final = '0;
      case (w_c_op)
         3'b000:                 w_final = w_fprod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_final = w_fprod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_final = w_c_neg_q ? -w_q : w_q;
         default:                w_final = w_c_neg_r ? -w_r : w_r;
      endcase
   end

   assign w_special = w_div0 ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);
   assign w_res_nxt = (w_idle & (w_div0 | w_ovf)) ? w_special : w_final;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (start) w_state_nxt = w_direct ? S_DONE : S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_a      <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_op    <= op;
         r_neg_q <= w_n1 ^ w_n2;
         r_neg_r <= w_n1;
         r_a     <= w_c_a;
         r_prod  <= w_step;
         r_cnt   <= CW'(XLEN);
         if (w_direct) r_result <= w_res_nxt;
      end else if ((r_state == S_CALC) && !flush) begin
         r_prod <= w_step;
         r_cnt  <= r_cnt - CW'(1);
         if (w_last) r_result <= w_res_nxt;
      end
   end

   always_comb begin
      busy = (r_state != S_IDLE);
      done = (r_state == S_DONE);
   end

   assign result = r_result;
endmodule
